// File: rtl/counter_pkg.sv
// Shared constants for the counter: load-value width and default counter width.
package counter_pkg;

  localparam int LOAD_W    = 16;
  localparam int DEF_WIDTH = 20;

endpackage : counter_pkg

// File: rtl/counter.sv
// Loadable wrap-detecting counter with registered count and wrap pulse.
// Define COUNTER_DOWN_EN to make dn select down-counting; otherwise dn is ignored.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              ld,
  input  logic              dn,
  input  logic [LOAD_W-1:0] ld_val,
  output logic [WIDTH-1:0]  cnt,
  output logic              ovf
);

  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1'b1);

  logic [WIDTH-1:0] cnt_r;
  logic             ovf_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic             ovf_nxt_s;
  logic [WIDTH-1:0] ld_ext_s;

`ifndef COUNTER_DOWN_EN
  logic unused_dn_s;
  assign unused_dn_s = dn;
`endif

  // Size cast zero-extends or truncates the load value to the counter width.
  assign ld_ext_s = WIDTH'(ld_val);

  // Next-state selection: clear, then load, then count, then hold.
  always_comb begin
    cnt_nxt_s = cnt_r;
    ovf_nxt_s = 1'b0;
    if (clr) begin
      cnt_nxt_s = '0;
      ovf_nxt_s = 1'b0;
    end else if (ld) begin
      cnt_nxt_s = ld_ext_s;
      ovf_nxt_s = 1'b0;
    end else if (en) begin
`ifdef COUNTER_DOWN_EN
      if (dn) begin
        cnt_nxt_s = cnt_r - ONE_C;
        ovf_nxt_s = ~|cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + ONE_C;
        ovf_nxt_s = &cnt_r;
      end
`else
      cnt_nxt_s = cnt_r + ONE_C;
      ovf_nxt_s = &cnt_r;
`endif
    end else begin
      cnt_nxt_s = cnt_r;
      ovf_nxt_s = 1'b0;
    end
  end

  // Count and wrap-pulse state; reset clears both immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign cnt = cnt_r;
  assign ovf = ovf_r;

endmodule : counter

// File: tb/tb_counter.sv
// Scoreboard bench driving WIDTH=4, 8 and 20 counters from shared stimulus.
module tb_counter;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        en;
  logic        ld;
  logic        dn;
  logic [15:0] ld_val;
  logic [3:0]  c4;
  logic [7:0]  c8;
  logic [19:0] c20;
  logic        o4;
  logic        o8;
  logic        o20;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] m4, m8, m20;
  logic [64:0] q4[$];
  logic [64:0] q8[$];
  logic [64:0] q20[$];

  counter #(.WIDTH(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .ld(ld), .dn(dn),
    .ld_val(ld_val), .cnt(c4), .ovf(o4)
  );
  counter #(.WIDTH(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .ld(ld), .dn(dn),
    .ld_val(ld_val), .cnt(c8), .ovf(o8)
  );
  counter u_c20 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .ld(ld), .dn(dn),
    .ld_val(ld_val), .cnt(c20), .ovf(o20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {ovf, next count} for a counter of width w.
  function automatic logic [64:0] mdl(input logic [63:0] c, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (clr)
      return {1'b0, 64'd0};
    else if (ld)
      return {1'b0, {48'd0, ld_val} & mask};
    else if (en) begin
`ifdef COUNTER_DOWN_EN
      if (dn)
        return (c == 64'd0) ? {1'b1, mask} : {1'b0, c - 64'd1};
`endif
      return (c == mask) ? {1'b1, 64'd0} : {1'b0, c + 64'd1};
    end
    return {1'b0, c};
  endfunction

  task automatic step();
    logic [64:0] r;
    r = mdl(m4, 4);   q4.push_back(r);  m4 = r[63:0];
    r = mdl(m8, 8);   q8.push_back(r);  m8 = r[63:0];
    r = mdl(m20, 20); q20.push_back(r); m20 = r[63:0];
    @(posedge clk);
    #1;
    r = q4.pop_front();
    chk("sb_cnt4", 64'(c4), r[63:0]);
    chk("sb_ovf4", 64'(o4), 64'(r[64]));
    r = q8.pop_front();
    chk("sb_cnt8", 64'(c8), r[63:0]);
    chk("sb_ovf8", 64'(o8), 64'(r[64]));
    r = q20.pop_front();
    chk("sb_cnt20", 64'(c20), r[63:0]);
    chk("sb_ovf20", 64'(o20), 64'(r[64]));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_c4"}, 64'(c4), 64'd0);
    chk({tag, "_c20"}, 64'(c20), 64'd0);
    chk({tag, "_ovf"}, 64'({o4, o8, o20}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; en = 1'b1; ld = 1'b0; dn = 1'b0; ld_val = 16'h0000;
    m4 = 64'd0; m8 = 64'd0; m20 = 64'd0;

    // Reset held for three edges with en=1
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_first", 64'(c4), 64'd1);

    // Free-run through the 4-bit wrap
    for (int i = 0; i < 14; i++) step();
    chk("run_15", 64'(c4), 64'd15);
    chk("run_15_ovf", 64'(o4), 64'd0);
    step();
    chk("wrap_cnt", 64'(c4), 64'd0);
    chk("wrap_ovf", 64'(o4), 64'd1);
    step();
    chk("post_wrap_cnt", 64'(c4), 64'd1);
    chk("post_wrap_ovf", 64'(o4), 64'd0);

    // Hold at 7
    ld = 1'b1; ld_val = 16'h0007;
    step();
    ld = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("hold7", 64'(c4), 64'd7);

    // Priority clr > ld > en
    clr = 1'b1; ld = 1'b1; en = 1'b1; ld_val = 16'h0005;
    step();
    chk("prio_clr", 64'(c20), 64'd0);
    clr = 1'b0;
    step();
    chk("prio_ld", 64'(c20), 64'd5);
    ld = 1'b0;
    step();
    chk("prio_en", 64'(c20), 64'd6);

    // Load width: zero-extend and truncate; loaded all-ones does not flag ovf
    ld = 1'b1; ld_val = 16'hFFFF;
    step();
    chk("ld_w20", 64'(c20), 64'h0FFFF);
    chk("ld_w8", 64'(c8), 64'hFF);
    chk("ld_ovf", 64'({o8, o20}), 64'd0);
    ld = 1'b0;
    step();
    chk("ld_w8_wrap", 64'(c8), 64'h00);
    chk("ld_w8_ovf", 64'(o8), 64'd1);
    chk("ld_w20_inc", 64'(c20), 64'h10000);

    // Direction from cnt=1
    ld = 1'b1; ld_val = 16'h0001;
    step();
    ld = 1'b0; dn = 1'b1;
    step();
`ifdef COUNTER_DOWN_EN
    chk("dn_1", 64'(c4), 64'd0);
    step();
    chk("dn_wrap", 64'(c4), 64'd15);
    chk("dn_wrap_ovf", 64'(o4), 64'd1);
`else
    chk("dn_ign_1", 64'(c4), 64'd2);
    step();
    chk("dn_ign_2", 64'(c4), 64'd3);
    chk("dn_ign_ovf", 64'(o4), 64'd0);
`endif
    dn = 1'b0;

    // Random stimulus through the scoreboard
    for (int i = 0; i < 300; i++) begin
      clr    = ($urandom_range(0, 19) == 0);
      ld     = ($urandom_range(0, 9) == 0);
      en     = ($urandom_range(0, 3) != 0);
      dn     = 1'($urandom_range(0, 1));
      ld_val = 16'($urandom);
      step();
    end

    // Async reset between edges aborts a pending wrap
    clr = 1'b0; en = 1'b1; dn = 1'b0; ld = 1'b1; ld_val = 16'h000F;
    step();
    ld = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    m4 = 64'd0; m8 = 64'd0; m20 = 64'd0;
    @(posedge clk);
    #1;
    chk_zero("rst_no_wrap");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_rel_cnt", 64'(c4), 64'd1);
    for (int i = 0; i < 20; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_counter
